// File: rtl/bram_word_writer_pkg.sv
// Shared state encoding and word geometry for the nibble-entry RAM writer.
package bram_word_writer_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam int NIBBLES_PER_WORD = 4;
  localparam int NIBBLE_W         = 4;

endpackage

// File: rtl/bram_word_writer_if.sv
// Switch/button inputs, RAM port-A write signals and preview outputs of the word writer.
interface bram_word_writer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  import bram_word_writer_pkg::*;

  logic [NIBBLE_W-1:0] sw;
  logic                btn_enter;
  logic                btn_back;
  logic                wea;
  logic [ADDR_W-1:0]   addra;
  logic [DATA_W-1:0]   dina;
  logic [DATA_W-1:0]   x;
  logic [1:0]          nib_cnt;
  logic                full;

  modport master (
    output sw, btn_enter, btn_back,
    input  wea, addra, dina, x, nib_cnt, full
  );

  modport slave (
    input  sw, btn_enter, btn_back,
    output wea, addra, dina, x, nib_cnt, full
  );

endinterface

// File: rtl/bram_word_writer_btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer; rise_p pulses in the
// same cycle the debounced level goes high.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  output logic level,
  output logic rise_p
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      count  <= '0;
      rise_p <= 1'b0;
    end else begin
      sync1  <= btn_in;
      sync2  <= sync1;
      rise_p <= 1'b0;
      // Any sample matching the current level is a bounce: restart the run.
      if (sync2 == level) begin
        count <= '0;
      end else if (count == CW'(DEB_CYCLES - 1)) begin
        level  <= sync2;
        count  <= '0;
        rise_p <= sync2;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_word_writer.sv
// Builds 16-bit words a nibble at a time from debounced buttons and writes
// them sequentially into block RAM port A, locking once every address is used.
module bram_word_writer
  import bram_word_writer_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16,
  parameter int DEB_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               clr,
  bram_word_writer_if.slave  bus
);

  logic              enter_p;
  logic              back_p;
  logic [1:0]        btn_lvl_unused;
  state_t            state;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] x;
  logic [1:0]        nib_cnt;
  logic              full;
  logic [DATA_W-1:0] x_shl;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk    (clk),
    .clr    (clr),
    .btn_in (bus.btn_enter),
    .level  (btn_lvl_unused[0]),
    .rise_p (enter_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
    .clk    (clk),
    .clr    (clr),
    .btn_in (bus.btn_back),
    .level  (btn_lvl_unused[1]),
    .rise_p (back_p)
  );

  assign x_shl = {x[DATA_W-NIBBLE_W-1:0], bus.sw};

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_COLLECT;
      wea     <= 1'b0;
      addra   <= '0;
      dina    <= '0;
      x       <= '0;
      nib_cnt <= 2'd0;
      full    <= 1'b0;
    end else begin
      wea <= 1'b0;
      case (state)
        ST_COLLECT: begin
          // Simultaneous enter and back are ambiguous, so neither acts.
          if (enter_p && !back_p) begin
            x <= x_shl;
            if (nib_cnt == 2'(NIBBLES_PER_WORD - 1)) begin
              dina  <= x_shl;
              wea   <= 1'b1;
              state <= ST_WRITE;
            end else begin
              nib_cnt <= nib_cnt + 2'd1;
            end
          end else if (back_p && !enter_p && nib_cnt != 2'd0) begin
            x       <= {{NIBBLE_W{1'b0}}, x[DATA_W-1:NIBBLE_W]};
            nib_cnt <= nib_cnt - 2'd1;
          end
        end
        ST_WRITE: begin
          x       <= '0;
          nib_cnt <= 2'd0;
          if (addra == {ADDR_W{1'b1}}) begin
            full  <= 1'b1;
            state <= ST_FULL;
          end else begin
            addra <= addra + ADDR_W'(1);
            state <= ST_COLLECT;
          end
        end
        ST_FULL: state <= ST_FULL;
        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.wea     = wea;
  assign bus.addra   = addra;
  assign bus.dina    = dina;
  assign bus.x       = x;
  assign bus.nib_cnt = nib_cnt;
  assign bus.full    = full;

endmodule

// File: tb/tb_bram_word_writer.sv
// Scenario bench for bram_word_writer: button presses against a queue-based model of the entry rules.
module tb_bram_word_writer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bram_word_writer_if bus ();

  bram_word_writer #(.ADDR_W(3), .DATA_W(16), .DEB_CYCLES(4)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the nibbles entered so far, the next address, full flag, last written word.
  logic [3:0]  mq[$];
  int          maddr = 0;
  bit          mfull = 0;
  logic [15:0] mdina = 16'h0;
  logic [18:0] exp_wr[$];

  // Observed RAM writes and over-long write pulses.
  logic [18:0] got_wr[$];
  int          long_pulses = 0;
  logic        wea_q = 1'b0;

  always @(negedge clk) begin
    if (bus.wea === 1'b1) got_wr.push_back({bus.addra, bus.dina});
    if (bus.wea === 1'b1 && wea_q === 1'b1) long_pulses++;
    wea_q = bus.wea;
  end

  function automatic logic [15:0] mx();
    logic [15:0] v = 16'h0;
    foreach (mq[i]) v = (v << 4) | 16'(mq[i]);
    return v;
  endfunction

  task automatic model_apply(input bit e, input bit b, input logic [3:0] v);
    if (mfull || (e && b)) return;
    if (e) begin
      mq.push_back(v);
      if (mq.size() == 4) begin
        mdina = mx();
        exp_wr.push_back({3'(maddr), mdina});
        mq.delete();
        if (maddr == 7) mfull = 1;
        else maddr++;
      end
    end else if (b && mq.size() > 0) begin
      void'(mq.pop_back());
    end
  endtask

  task automatic model_reset();
    mq.delete();
    maddr = 0;
    mfull = 0;
    mdina = 16'h0;
  endtask

  task automatic press(input bit e, input bit b, input logic [3:0] v);
    @(negedge clk);
    bus.sw = v;
    bus.btn_enter = e;
    bus.btn_back = b;
    repeat (10) @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_back = 1'b0;
    repeat (10) @(negedge clk);
    model_apply(e, b, v);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.sw = 4'h0;
    bus.btn_enter = 1'b1;
    bus.btn_back = 1'b0;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.wea, bus.addra, bus.dina, bus.x, bus.nib_cnt, bus.full} !== 39'h0) begin
      errors++;
      $display("FAIL reset_outputs: got wea=%b addra=%0d dina=%h x=%h nib=%0d full=%b, want all 0",
               bus.wea, bus.addra, bus.dina, bus.x, bus.nib_cnt, bus.full);
    end
    repeat (8) @(negedge clk);
    clr = 1'b0;
    bus.btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.nib_cnt !== 2'd0 || bus.x !== 16'h0 || got_wr.size() != 0) begin
      errors++;
      $display("FAIL reset_held_btn: got nib=%0d x=%h writes=%0d, want 0 0 0",
               bus.nib_cnt, bus.x, got_wr.size());
    end
  endtask

  task automatic test_word_write();
    logic [15:0] prev [3] = '{16'h000A, 16'h00AB, 16'h0ABC};
    logic [3:0]  nibs [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, nibs[i]);
      if (i < 3) begin
        checks++;
        if (bus.x !== prev[i] || bus.x !== mx() || bus.nib_cnt !== 2'(i + 1)) begin
          errors++;
          $display("FAIL word_preview%0d: got x=%h nib=%0d, want x=%h nib=%0d",
                   i, bus.x, bus.nib_cnt, prev[i], i + 1);
        end
      end
    end
    checks++;
    if (got_wr.size() != 1 || got_wr[0] !== {3'd0, 16'hABCD}) begin
      errors++;
      $display("FAIL word_write: got %0d writes first=%h, want 1 write %h",
               got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 19'h0, {3'd0, 16'hABCD});
    end
    checks++;
    if (bus.x !== 16'h0 || bus.nib_cnt !== 2'd0 || bus.addra !== 3'd1 ||
        bus.dina !== 16'hABCD || long_pulses != 0) begin
      errors++;
      $display("FAIL word_after: got x=%h nib=%0d addra=%0d dina=%h long=%0d, want 0 0 1 abcd 0",
               bus.x, bus.nib_cnt, bus.addra, bus.dina, long_pulses);
    end
  endtask

  task automatic test_backspace();
    press(1'b0, 1'b1, 4'h9);
    checks++;
    if (bus.x !== 16'h0 || bus.nib_cnt !== 2'd0) begin
      errors++;
      $display("FAIL back_empty: got x=%h nib=%0d, want 0 0", bus.x, bus.nib_cnt);
    end
    press(1'b1, 1'b0, 4'h1);
    press(1'b1, 1'b0, 4'h2);
    press(1'b1, 1'b0, 4'h3);
    press(1'b0, 1'b1, 4'h0);
    checks++;
    if (bus.x !== 16'h0012 || bus.nib_cnt !== 2'd2) begin
      errors++;
      $display("FAIL back_delete: got x=%h nib=%0d, want 0012 2", bus.x, bus.nib_cnt);
    end
    press(1'b1, 1'b0, 4'h4);
    press(1'b1, 1'b0, 4'h5);
    checks++;
    if (got_wr.size() != 2 || got_wr[1] !== {3'd1, 16'h1245} || exp_wr[1] !== got_wr[1]) begin
      errors++;
      $display("FAIL back_write: got %0d writes last=%h, want %h",
               got_wr.size(), got_wr[got_wr.size()-1], {3'd1, 16'h1245});
    end
  endtask

  task automatic test_bounce();
    logic [15:0] x_before;
    @(negedge clk);
    bus.sw = 4'h7;
    for (int i = 0; i < 10; i++) begin
      bus.btn_enter = ~i[0];
      repeat (2) @(negedge clk);
    end
    bus.btn_enter = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    model_apply(1'b1, 1'b0, 4'h7);
    checks++;
    if (bus.x !== 16'h0007 || bus.nib_cnt !== 2'd1) begin
      errors++;
      $display("FAIL bounce_once: got x=%h nib=%0d, want 0007 1", bus.x, bus.nib_cnt);
    end
    x_before = mx();
    press(1'b1, 1'b1, 4'hE);
    checks++;
    if (bus.x !== x_before || bus.nib_cnt !== 2'(mq.size())) begin
      errors++;
      $display("FAIL both_buttons: got x=%h nib=%0d, want %h %0d",
               bus.x, bus.nib_cnt, x_before, mq.size());
    end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      press(sel <= 5 || sel == 9, sel >= 6, 4'($urandom_range(0, 15)));
      checks++;
      if (bus.x !== mx() || bus.nib_cnt !== 2'(mq.size()) || bus.addra !== 3'(maddr) ||
          bus.full !== mfull || bus.dina !== mdina) begin
        errors++;
        $display("FAIL random_op%0d: got x=%h nib=%0d addra=%0d full=%b dina=%h, want %h %0d %0d %b %h",
                 i, bus.x, bus.nib_cnt, bus.addra, bus.full, bus.dina,
                 mx(), mq.size(), maddr, mfull, mdina);
      end
    end
    checks++;
    if (got_wr != exp_wr || long_pulses != 0) begin
      errors++;
      $display("FAIL random_writes: got %0d writes long=%0d, want %0d writes long=0",
               got_wr.size(), long_pulses, exp_wr.size());
    end
  endtask

  task automatic test_fill();
    int base;
    do_clr();
    base = got_wr.size();
    for (int w = 0; w < 8; w++)
      for (int n = 0; n < 4; n++) press(1'b1, 1'b0, 4'(w));
    checks++;
    if (got_wr.size() != base + 8) begin
      errors++;
      $display("FAIL fill_count: got %0d writes, want 8", got_wr.size() - base);
    end else begin
      for (int w = 0; w < 8; w++) begin
        checks++;
        if (got_wr[base + w] !== {3'(w), {4{4'(w)}}}) begin
          errors++;
          $display("FAIL fill_word%0d: got %h, want %h", w, got_wr[base + w], {3'(w), {4{4'(w)}}});
        end
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.addra !== 3'd7 || !mfull) begin
      errors++;
      $display("FAIL fill_full: got full=%b addra=%0d, want 1 7", bus.full, bus.addra);
    end
    for (int n = 0; n < 4; n++) press(1'b1, 1'b0, 4'h9);
    checks++;
    if (got_wr.size() != base + 8 || bus.x !== 16'h0 || bus.nib_cnt !== 2'd0) begin
      errors++;
      $display("FAIL full_locked: got extra=%0d x=%h nib=%0d, want 0 0000 0",
               got_wr.size() - base - 8, bus.x, bus.nib_cnt);
    end
    do_clr();
    @(negedge clk);
    checks++;
    if (bus.full !== 1'b0 || bus.addra !== 3'd0) begin
      errors++;
      $display("FAIL full_clear: got full=%b addra=%0d, want 0 0", bus.full, bus.addra);
    end
  endtask

  task automatic test_reset_mid_word();
    int base = got_wr.size();
    press(1'b1, 1'b0, 4'h3);
    press(1'b1, 1'b0, 4'h6);
    press(1'b1, 1'b0, 4'h9);
    checks++;
    if (bus.x !== 16'h0369 || bus.nib_cnt !== 2'd3) begin
      errors++;
      $display("FAIL mid_setup: got x=%h nib=%0d, want 0369 3", bus.x, bus.nib_cnt);
    end
    do_clr();
    repeat (12) @(negedge clk);
    checks++;
    if (bus.x !== 16'h0 || bus.nib_cnt !== 2'd0 || bus.addra !== 3'd0 || got_wr.size() != base) begin
      errors++;
      $display("FAIL mid_reset: got x=%h nib=%0d addra=%0d new_writes=%0d, want 0 0 0 0",
               bus.x, bus.nib_cnt, bus.addra, got_wr.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_backspace();
    test_bounce();
    test_random();
    test_fill();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
